if_fetch: RTL

- Instruction-fetch stage that owns the PC and drives the instruction bus.
- Presents if_pc/if_inst to the IF/ID latch and raises stallreq_if to ctrl while a fetch is outstanding.
- Applies branch redirects with MIPS delay-slot semantics and exception redirects (flush).
- Discards in-flight fetches that a redirect has made stale.

---
 rtl/if_fetch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction bus, presents
// the fetched word to the IF/ID latch and requests a pipeline stall while a
// fetch is outstanding. Branches redirect after the delay slot and flushes
// redirect immediately, dropping any fetch made stale by the redirect.
module if_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_ack_i,
  input  logic [31:0]       ibus_rdata_i,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic              stallreq_if
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              branch_pending;
  logic [ADDR_W-1:0] branch_target_q;
  logic [31:0]       inst_buf;
  logic [ADDR_W-1:0] discard_addr;

  logic              branch_now;
  logic              advance;
  logic [ADDR_W-1:0] next_pc;
  logic              unused_stall;

  // Only the PC-freeze and ID-advance bits of the stall vector matter here.
  assign unused_stall = ^{stall[5:3], stall[1]};

  // Instruction addresses are word aligned; the low two bits are always cleared.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  // Branch resolution, PC-advance condition and next sequential/redirect PC.
  always_comb begin
    branch_now = branch_flag_i & ~stall[2];
    advance    = ~flush & ~stall[0] &
                 (((state == S_FETCH) & ibus_ack_i) | (state == S_HOLD));
    if (branch_now)
      next_pc = word_align(branch_target_i);
    else if (branch_pending)
      next_pc = branch_target_q;
    else
      next_pc = word_align(pc + ADDR_W'(4));
  end

  // Bus request and IF/ID-facing outputs, all forced to zero while in reset.
  always_comb begin
    ibus_req_o  = 1'b0;
    ibus_addr_o = '0;
    if_pc       = '0;
    if_inst     = '0;
    stallreq_if = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ibus_req_o  = 1'b1;
          ibus_addr_o = pc;
          if (ibus_ack_i) begin
            if (!flush) begin
              if_pc   = pc;
              if_inst = ibus_rdata_i;
            end
          end else begin
            stallreq_if = 1'b1;
          end
        end
        S_HOLD: begin
          if (!flush) begin
            if_pc   = pc;
            if_inst = inst_buf;
          end
        end
        S_DISCARD: begin
          ibus_req_o  = 1'b1;
          ibus_addr_o = discard_addr;
          stallreq_if = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Fetch FSM, PC register, held instruction and delay-slot branch latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      pc              <= word_align(RESET_PC);
      branch_pending  <= 1'b0;
      branch_target_q <= '0;
      inst_buf        <= '0;
    end else if (flush) begin
      pc             <= word_align(new_pc);
      branch_pending <= 1'b0;
      case (state)
        S_FETCH:   state <= ibus_ack_i ? S_FETCH : S_DISCARD;
        S_DISCARD: state <= ibus_ack_i ? S_FETCH : S_DISCARD;
        default:   state <= S_FETCH;
      endcase
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (ibus_ack_i) begin
            if (!stall[0]) begin
              pc <= next_pc;
            end else begin
              inst_buf <= ibus_rdata_i;
              state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall[0]) begin
            pc    <= next_pc;
            state <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (ibus_ack_i)
            state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
      if (advance) begin
        branch_pending <= 1'b0;
      end else if (branch_now) begin
        branch_pending  <= 1'b1;
        branch_target_q <= word_align(branch_target_i);
      end
    end
  end

  // Remember the address of a fetch abandoned by a flush so the bus sees it held.
  always_ff @(posedge clk) begin
    if (!rst && flush && (state == S_FETCH) && !ibus_ack_i)
      discard_addr <= pc;
  end

endmodule
